axi_stream_header_arbiter: RTL and testbench
============================================

Name: axi_stream_header_arbiter

Overview:
- Shares one header-insertion datapath between NUM_SRC independent requesters. Each requester has an AXI-Stream payload channel and a header channel.
- Grants one source per packet, round-robin. Routes that source's header and payload onto the shared insertion block's input ports. Holds the grant until the payload last beat handshakes.
- Sits directly upstream of the header-insert datapath. Its m_* ports connect one-to-one to that block's stream and header inputs.

Parameters:
- NUM_SRC, 4, number of requesters (2..16).
- DATA_WD, 32, payload/header data width in bits.
- DATA_BYTE_WD, DATA_WD/8, keep width.
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD), byte_insert_cnt width.
- GRANT_WD, $clog2(NUM_SRC), grant index width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- s_valid_in  in  NUM_SRC  per-source payload valid.
- s_data_in  in  NUM_SRC*DATA_WD  per-source payload data, source i at [i*DATA_WD +: DATA_WD].
- s_keep_in  in  NUM_SRC*DATA_BYTE_WD  per-source payload keep.
- s_last_in  in  NUM_SRC  per-source payload last.
- s_ready_in  out  NUM_SRC  per-source payload ready.
- s_valid_insert  in  NUM_SRC  per-source header valid; this is the request.
- s_data_insert  in  NUM_SRC*DATA_WD  per-source header data.
- s_keep_insert  in  NUM_SRC*DATA_BYTE_WD  per-source header keep.
- s_byte_insert_cnt  in  NUM_SRC*BYTE_CNT_WD  per-source header byte count.
- s_ready_insert  out  NUM_SRC  per-source header ready.
- m_valid_in, m_data_in, m_keep_in, m_last_in  out  1/DATA_WD/DATA_BYTE_WD/1  payload to insertion block.
- m_ready_in  in  1  payload ready from insertion block.
- m_valid_insert, m_data_insert, m_keep_insert, m_byte_insert_cnt  out  1/DATA_WD/DATA_BYTE_WD/BYTE_CNT_WD  header to insertion block.
- m_ready_insert  in  1  header ready from insertion block.
- busy  out  1  a packet grant is held.
- grant_id  out  GRANT_WD  index of the current/last granted source.
- protocol_err  out  1  sticky error flag, cleared only by rst.

Behaviour:
- FSM states: IDLE and LOCK. Reset → IDLE; busy=0; grant_id=0; last_grant=NUM_SRC-1; hdr_done=0; protocol_err=0.
- Every m_valid_*, s_ready_* and m_* data output is 0 in IDLE and during reset.
- IDLE: request vector = s_valid_insert.
  - If any bit is set, pick the first set index searching from last_grant+1 (mod NUM_SRC) upward.
  - Register it into grant_id; clear hdr_done; go to LOCK.
  - Arbitration latency is 1 cycle: no routing in the decision cycle.
  - Payload valid without header valid is not a request.
- LOCK, grant g:
  - Payload channel routed combinationally: m_valid_in=s_valid_in[g], m_data_in/m_keep_in/m_last_in from g, s_ready_in[g]=m_ready_in.
  - Header channel routed only while hdr_done=0: m_valid_insert=s_valid_insert[g], s_ready_insert[g]=m_ready_insert. When hdr_done=1, m_valid_insert=0 and s_ready_insert[g]=0.
  - Non-granted sources: s_ready_*=0.
  - Header handshake (m_valid_insert & m_ready_insert) sets hdr_done.
  - Payload handshake with last (m_valid_in & m_ready_in & m_last_in) → IDLE; last_grant<=g.
  - Header handshake and last handshake in the same cycle (single-beat packet) is legal → IDLE.
  - Last handshake with hdr_done=0 and no same-cycle header handshake → set protocol_err and still return to IDLE.
- Back-to-back packets: at least one IDLE cycle between packets, so sustained throughput is packet_len+1 cycles per packet.
- Routing is purely combinational from registered grant/state; no data registers are added in the path.
- Reset asserted mid-packet: immediate return to IDLE; all readies and valids drop asynchronously.

Test Plan:
- Single source 1 requesting; header cnt=1, 3-beat packet with m_ready_in=1 → grant_id=1 one cycle after request; three payload handshakes plus one header handshake; busy falls the cycle after the last beat; s_ready_in[0,2,3]=0 throughout.
- All 4 sources request continuously with 2-beat packets → grant order 0,1,2,3,0; exactly one IDLE cycle between packets.
- Single-beat packet: header and last handshake in the same cycle → hdr_done irrelevant, returns to IDLE, protocol_err stays 0.
- After the header handshake, source keeps s_valid_insert=1 for its next header → m_valid_insert=0 and s_ready_insert[g]=0 until the packet ends; that header is served at the source's next grant.
- m_ready_in toggling 1,0,1,0 mid-packet → data held stable on m_data_in; no beat lost or duplicated; grant held.
- Payload last handshake before any header handshake → protocol_err=1 (sticky); FSM in IDLE; rst mid-packet → all outputs 0 and grant_id=0 immediately.

Source files
------------

// File: rtl/axi_stream_header_arbiter.sv
// axi_stream_header_arbiter
// Shares one header-insertion datapath between NUM_SRC requesters. A source
// requests by raising its header valid; one source is granted per packet in
// round-robin order. Its header and payload channels are then routed
// combinationally to the m_* ports. The grant is held until the payload last
// beat handshakes.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   s_*_in                   per-source payload channels (valid/data/keep/last/ready)
//   s_*_insert               per-source header channels (valid/data/keep/cnt/ready)
//   m_*_in                   payload towards the insertion block
//   m_*_insert               header towards the insertion block
//   busy                     a packet grant is currently held
//   grant_id                 index of the current / most recent grant
//   protocol_err             sticky: a packet ended before its header was taken
module axi_stream_header_arbiter #(
  parameter int NUM_SRC      = 4,
  parameter int DATA_WD      = 32,
  parameter int DATA_BYTE_WD = DATA_WD / 8,
  parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
  parameter int GRANT_WD     = $clog2(NUM_SRC)
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                s_valid_in,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_in,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_in,
  input  logic [NUM_SRC-1:0]                s_last_in,
  output logic [NUM_SRC-1:0]                s_ready_in,
  input  logic [NUM_SRC-1:0]                s_valid_insert,
  input  logic [NUM_SRC*DATA_WD-1:0]        s_data_insert,
  input  logic [NUM_SRC*DATA_BYTE_WD-1:0]   s_keep_insert,
  input  logic [NUM_SRC*BYTE_CNT_WD-1:0]    s_byte_insert_cnt,
  output logic [NUM_SRC-1:0]                s_ready_insert,
  output logic                              m_valid_in,
  output logic [DATA_WD-1:0]                m_data_in,
  output logic [DATA_BYTE_WD-1:0]           m_keep_in,
  output logic                              m_last_in,
  input  logic                              m_ready_in,
  output logic                              m_valid_insert,
  output logic [DATA_WD-1:0]                m_data_insert,
  output logic [DATA_BYTE_WD-1:0]           m_keep_insert,
  output logic [BYTE_CNT_WD-1:0]            m_byte_insert_cnt,
  input  logic                              m_ready_insert,
  output logic                              busy,
  output logic [GRANT_WD-1:0]               grant_id,
  output logic                              protocol_err
);

  typedef enum logic {ST_IDLE, ST_LOCK} state_t;

  state_t              r_state, w_state_next;
  logic [GRANT_WD-1:0] r_grant, w_grant_next;
  logic [GRANT_WD-1:0] r_last_grant, w_last_grant_next;
  logic                r_hdr_done, w_hdr_done_next;
  logic                r_err, w_err_next;

  logic [GRANT_WD-1:0] w_pick;
  logic                w_any_req;
  logic                w_locked;
  logic                w_hdr_open;
  logic                w_hdr_hs;
  logic                w_last_hs;

  // Round-robin search: first requesting index after the last granted one.
  always_comb begin : rr_pick
    int idx;
    idx       = 0;
    w_pick    = '0;
    w_any_req = 1'b0;
    for (int k = 1; k <= NUM_SRC; k++) begin
      idx = (int'(r_last_grant) + k) % NUM_SRC;
      if (!w_any_req && s_valid_insert[idx]) begin
        w_any_req = 1'b1;
        w_pick    = GRANT_WD'(idx);
      end
    end
  end

  assign w_locked   = (r_state == ST_LOCK);
  // The header path closes once this packet's header has been accepted, so a
  // source presenting its next header early is held off until its next grant.
  assign w_hdr_open = w_locked & ~r_hdr_done;

  // Payload routing: valid only while a grant is held, data forced to zero otherwise.
  assign m_valid_in = w_locked & s_valid_in[r_grant];
  assign m_last_in  = w_locked & s_last_in[r_grant];
  assign m_data_in  = w_locked ? s_data_in[r_grant*DATA_WD +: DATA_WD] : '0;
  assign m_keep_in  = w_locked ? s_keep_in[r_grant*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;

  // Header routing: header fields are also zeroed once the header is done.
  assign m_valid_insert    = w_hdr_open & s_valid_insert[r_grant];
  assign m_data_insert     = w_hdr_open ? s_data_insert[r_grant*DATA_WD +: DATA_WD] : '0;
  assign m_keep_insert     = w_hdr_open ? s_keep_insert[r_grant*DATA_BYTE_WD +: DATA_BYTE_WD] : '0;
  assign m_byte_insert_cnt = w_hdr_open ? s_byte_insert_cnt[r_grant*BYTE_CNT_WD +: BYTE_CNT_WD] : '0;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_SRC; gi++) begin : g_ready
      assign s_ready_in[gi]     = w_locked   & (r_grant == GRANT_WD'(gi)) & m_ready_in;
      assign s_ready_insert[gi] = w_hdr_open & (r_grant == GRANT_WD'(gi)) & m_ready_insert;
    end
  endgenerate

  assign w_hdr_hs  = m_valid_insert & m_ready_insert;
  assign w_last_hs = m_valid_in & m_ready_in & m_last_in;

  always_comb begin
    w_state_next      = r_state;
    w_grant_next      = r_grant;
    w_last_grant_next = r_last_grant;
    w_hdr_done_next   = r_hdr_done;
    w_err_next        = r_err;
    case (r_state)
      ST_IDLE: begin
        if (w_any_req) begin
          w_grant_next    = w_pick;
          w_hdr_done_next = 1'b0;
          w_state_next    = ST_LOCK;
        end
      end
      ST_LOCK: begin
        if (w_hdr_hs) begin
          w_hdr_done_next = 1'b1;
        end
        if (w_last_hs) begin
          w_state_next      = ST_IDLE;
          w_last_grant_next = r_grant;
          // Packet finished without its header ever being taken.
          if (!r_hdr_done && !w_hdr_hs) begin
            w_err_next = 1'b1;
          end
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_grant      <= '0;
      r_last_grant <= GRANT_WD'(NUM_SRC - 1);
      r_hdr_done   <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_last_grant <= w_last_grant_next;
      r_hdr_done   <= w_hdr_done_next;
      r_err        <= w_err_next;
    end
  end

  assign busy         = w_locked;
  assign grant_id     = r_grant;
  assign protocol_err = r_err;

endmodule

// File: tb/tb_axi_stream_header_arbiter.sv
// Testbench for axi_stream_header_arbiter: behavioural sources drive packets,
// a packet-level reference model predicts every routed output each cycle.
module tb_axi_stream_header_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int BW = 4;
  localparam int CW = 2;
  localparam int GW = 2;

  logic clk = 1'b0;
  logic rst;
  logic [N-1:0]    s_valid_in, s_last_in, s_ready_in;
  logic [N-1:0]    s_valid_insert, s_ready_insert;
  logic [N*DW-1:0] s_data_in, s_data_insert;
  logic [N*BW-1:0] s_keep_in, s_keep_insert;
  logic [N*CW-1:0] s_byte_insert_cnt;
  logic            m_valid_in, m_last_in, m_ready_in;
  logic            m_valid_insert, m_ready_insert;
  logic [DW-1:0]   m_data_in, m_data_insert;
  logic [BW-1:0]   m_keep_in, m_keep_insert;
  logic [CW-1:0]   m_byte_insert_cnt;
  logic            busy, protocol_err;
  logic [GW-1:0]   grant_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  axi_stream_header_arbiter #(.NUM_SRC(N), .DATA_WD(DW)) dut (
    .clk(clk), .rst(rst),
    .s_valid_in(s_valid_in), .s_data_in(s_data_in), .s_keep_in(s_keep_in),
    .s_last_in(s_last_in), .s_ready_in(s_ready_in),
    .s_valid_insert(s_valid_insert), .s_data_insert(s_data_insert),
    .s_keep_insert(s_keep_insert), .s_byte_insert_cnt(s_byte_insert_cnt),
    .s_ready_insert(s_ready_insert),
    .m_valid_in(m_valid_in), .m_data_in(m_data_in), .m_keep_in(m_keep_in),
    .m_last_in(m_last_in), .m_ready_in(m_ready_in),
    .m_valid_insert(m_valid_insert), .m_data_insert(m_data_insert),
    .m_keep_insert(m_keep_insert), .m_byte_insert_cnt(m_byte_insert_cnt),
    .m_ready_insert(m_ready_insert),
    .busy(busy), .grant_id(grant_id), .protocol_err(protocol_err)
  );

  // Reference model: packet-level view of the arbiter.
  int md_busy, md_g, md_last, md_hdr, md_err;

  // Source behaviour
  int src_len[N], src_sent[N], src_pkt[N], src_salt[N];
  bit src_active[N], src_hdr_ok[N], src_early[N], src_auto[N], src_hold[N];
  int len_lo = 1, len_hi = 1;
  bit rnd_ready = 1'b0;
  bit fix_ready_in = 1'b1, fix_ready_ins = 1'b1;
  logic [N-1:0] hs_hdr, hs_pay;
  int cnt_pay[N], cnt_hdr[N];

  // Grant trace
  int glog[$];
  int gaps[$];
  int idle_run = 0;
  bit prev_busy = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_pkt(input int i);
    src_active[i] = 1'b1;
    src_sent[i]   = 0;
    src_hdr_ok[i] = 1'b0;
    src_len[i]    = $urandom_range(len_lo, len_hi);
    src_salt[i]   = int'($urandom_range(0, 65535));
  endtask

  function automatic bit all_idle();
    bit r = 1'b1;
    for (int i = 0; i < N; i++) if (src_active[i]) r = 1'b0;
    return r;
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_valid_insert[i]            = (src_active[i] && !src_hdr_ok[i]) || src_hold[i];
      s_data_insert[i*DW +: DW]    = {8'(160 + i), 8'(src_pkt[i]), 16'(src_salt[i]) ^ 16'h5a5a};
      s_keep_insert[i*BW +: BW]    = 4'(15 >> (src_pkt[i] % 4));
      s_byte_insert_cnt[i*CW +: CW] = CW'(src_pkt[i] + i);
      s_valid_in[i]                = src_active[i] && (src_hdr_ok[i] || src_early[i]) &&
                                     (src_sent[i] < src_len[i]);
      s_data_in[i*DW +: DW]        = {4'(i), 4'(src_sent[i]), 8'(src_pkt[i]), 16'(src_salt[i])};
      s_last_in[i]                 = (src_sent[i] == src_len[i] - 1);
      s_keep_in[i*BW +: BW]        = s_last_in[i] ? 4'b0111 : 4'b1111;
    end
    m_ready_in     = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready_in;
    m_ready_insert = rnd_ready ? 1'($urandom_range(0, 1)) : fix_ready_ins;
  endtask

  // One clock cycle: drive, compare routed outputs against the model, advance.
  task automatic step();
    int nb, ng, nl, nh, ne, j;
    bit open, hh, lh;
    drive();
    #1;
    open = (md_busy != 0) && (md_hdr == 0);
    chk("busy", busy, md_busy);
    chk("grant_id", grant_id, md_g);
    chk("protocol_err", protocol_err, md_err);
    chk("m_valid_in", m_valid_in, md_busy ? s_valid_in[md_g] : 1'b0);
    chk("m_data_in", m_data_in, md_busy ? s_data_in[md_g*DW +: DW] : '0);
    chk("m_keep_in", m_keep_in, md_busy ? s_keep_in[md_g*BW +: BW] : '0);
    chk("m_last_in", m_last_in, md_busy ? s_last_in[md_g] : 1'b0);
    chk("m_valid_insert", m_valid_insert, open ? s_valid_insert[md_g] : 1'b0);
    chk("m_data_insert", m_data_insert, open ? s_data_insert[md_g*DW +: DW] : '0);
    chk("m_keep_insert", m_keep_insert, open ? s_keep_insert[md_g*BW +: BW] : '0);
    chk("m_byte_insert_cnt", m_byte_insert_cnt, open ? s_byte_insert_cnt[md_g*CW +: CW] : '0);
    chk("s_ready_in", s_ready_in, md_busy ? (int'(m_ready_in) << md_g) : 0);
    chk("s_ready_insert", s_ready_insert, open ? (int'(m_ready_insert) << md_g) : 0);

    if (busy && !prev_busy) begin
      glog.push_back(int'(grant_id));
      gaps.push_back(idle_run);
    end
    idle_run  = busy ? 0 : idle_run + 1;
    prev_busy = busy;

    hs_hdr = s_valid_insert & s_ready_insert;
    hs_pay = s_valid_in & s_ready_in;

    nb = md_busy; ng = md_g; nl = md_last; nh = md_hdr; ne = md_err;
    if (md_busy == 0) begin
      for (int k = 1; k <= N; k++) begin
        j = (md_last + k) % N;
        if (nb == 0 && s_valid_insert[j]) begin
          nb = 1; ng = j; nh = 0;
        end
      end
    end else begin
      hh = (md_hdr == 0) && s_valid_insert[md_g] && m_ready_insert;
      lh = s_valid_in[md_g] && m_ready_in && s_last_in[md_g];
      if (hh) nh = 1;
      if (lh) begin
        nb = 0; nl = md_g;
        if (md_hdr == 0 && !hh) ne = 1;
      end
    end

    @(posedge clk);
    md_busy = nb; md_g = ng; md_last = nl; md_hdr = nh; md_err = ne;
    for (int i = 0; i < N; i++) begin
      if (hs_hdr[i]) begin
        src_hdr_ok[i] = 1'b1;
        cnt_hdr[i]++;
      end
      if (hs_pay[i]) begin
        cnt_pay[i]++;
        src_sent[i]++;
        if (src_sent[i] >= src_len[i]) begin
          src_pkt[i]++;
          if (src_auto[i]) start_pkt(i);
          else src_active[i] = 1'b0;
        end
      end
    end
    #1;
  endtask

  task automatic clear_sources();
    for (int i = 0; i < N; i++) begin
      src_active[i] = 1'b0; src_hdr_ok[i] = 1'b0; src_early[i] = 1'b0;
      src_auto[i] = 1'b0;   src_hold[i] = 1'b0;   src_sent[i] = 0;
      src_len[i] = 0;       cnt_pay[i] = 0;       cnt_hdr[i] = 0;
    end
    rnd_ready = 1'b0; fix_ready_in = 1'b1; fix_ready_ins = 1'b1;
  endtask

  // Assert reset between edges and check that everything drops at once.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_grant_id", grant_id, 0);
    chk("rst_protocol_err", protocol_err, 0);
    chk("rst_m_valid", {m_valid_in, m_valid_insert}, 0);
    chk("rst_s_ready", {s_ready_in, s_ready_insert}, 0);
    chk("rst_m_data", {m_data_in, m_data_insert}, 0);
    clear_sources();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    md_busy = 0; md_g = 0; md_last = N - 1; md_hdr = 0; md_err = 0;
    glog.delete(); gaps.delete(); idle_run = 0; prev_busy = 1'b0;
  endtask

  task automatic drain(input int budget, input string tag);
    for (int i = 0; i < N; i++) begin
      src_auto[i] = 1'b0;
      src_hold[i] = 1'b0;
    end
    for (int c = 0; c < budget && !all_idle(); c++) step();
    chk(tag, all_idle(), 1);
  endtask

  initial begin
    int exp_order[5];
    logic [N-1:0] other_ready;
    exp_order = '{0, 1, 2, 3, 0};
    s_valid_in = '0; s_data_in = '0; s_keep_in = '0; s_last_in = '0;
    s_valid_insert = '0; s_data_insert = '0; s_keep_insert = '0; s_byte_insert_cnt = '0;
    m_ready_in = 1'b0; m_ready_insert = 1'b0;
    do_reset();

    // Single source 1, 3-beat packet, header after grant.
    len_lo = 3; len_hi = 3;
    start_pkt(1);
    other_ready = '0;
    step();
    chk("t1_grant", grant_id, 1);
    chk("t1_busy", busy, 1);
    for (int c = 0; c < 20 && src_active[1]; c++) begin
      other_ready |= s_ready_in & 4'b1101;
      step();
    end
    chk("t1_done", src_active[1], 0);
    chk("t1_pay_beats", cnt_pay[1], 3);
    chk("t1_hdr_beats", cnt_hdr[1], 1);
    chk("t1_busy_fall", busy, 0);
    chk("t1_other_ready", other_ready, 0);

    // All sources, 2-beat packets with header alongside the first beat.
    do_reset();
    len_lo = 2; len_hi = 2;
    for (int i = 0; i < N; i++) begin
      src_auto[i] = 1'b1;
      src_early[i] = 1'b1;
      start_pkt(i);
    end
    for (int c = 0; c < 16; c++) step();
    chk("t2_grants", glog.size() >= 5, 1);
    for (int k = 0; k < 5 && k < glog.size(); k++) begin
      chk($sformatf("t2_order%0d", k), glog[k], exp_order[k]);
      chk($sformatf("t2_gap%0d", k), gaps[k], 1);
    end
    drain(60, "t2_drain");

    // Single-beat packet: header and last in the same cycle.
    do_reset();
    len_lo = 1; len_hi = 1;
    src_early[0] = 1'b1;
    start_pkt(0);
    for (int c = 0; c < 10 && src_active[0]; c++) step();
    chk("t3_done", src_active[0], 0);
    step();
    chk("t3_err", protocol_err, 0);
    chk("t3_idle", busy, 0);

    // Next header held high while the current packet is still running.
    len_lo = 3; len_hi = 3;
    src_auto[2] = 1'b1;
    src_hold[2] = 1'b1;
    start_pkt(2);
    for (int c = 0; c < 40 && cnt_pay[2] < 6; c++) step();
    chk("t4_pay_beats", cnt_pay[2], 6);
    chk("t4_hdr_beats", cnt_hdr[2], 2);
    drain(30, "t4_drain");

    // Payload ready toggling mid-packet.
    len_lo = 4; len_hi = 4;
    start_pkt(3);
    for (int c = 0; c < 30 && src_active[3]; c++) begin
      fix_ready_in = c[0];
      step();
    end
    fix_ready_in = 1'b1;
    chk("t5_done", src_active[3], 0);
    chk("t5_pay_beats", cnt_pay[3], 4);

    // Randomized traffic from all sources.
    do_reset();
    len_lo = 1; len_hi = 5;
    rnd_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      src_auto[i] = 1'b1;
      start_pkt(i);
    end
    for (int c = 0; c < 400; c++) step();
    drain(300, "rnd_drain");
    rnd_ready = 1'b0;
    chk("rnd_err", protocol_err, 0);

    // Last beat before the header: sticky error.
    len_lo = 1; len_hi = 1;
    fix_ready_ins = 1'b0;
    src_early[1] = 1'b1;
    start_pkt(1);
    for (int c = 0; c < 10 && src_active[1]; c++) step();
    step();
    chk("t6_err", protocol_err, 1);
    chk("t6_idle", busy, 0);
    fix_ready_ins = 1'b1;
    src_early[1] = 1'b0;
    len_lo = 2; len_hi = 2;
    start_pkt(0);
    for (int c = 0; c < 10 && src_active[0]; c++) step();
    chk("t6_err_sticky", protocol_err, 1);

    // Reset in the middle of a packet.
    len_lo = 5; len_hi = 5;
    start_pkt(2);
    for (int c = 0; c < 3; c++) step();
    chk("t6_midpkt_busy", busy, 1);
    do_reset();
    step();
    chk("post_rst_idle", busy, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
